// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: 3x3 window generator for a Sobel datapath.
// Four line buffers are written in raster order. Once three complete lines are held, the read
// FSM issues one 3x3 window per cycle across the line.
// Optional feature macro: SOBEL_WINDOW_CTRL_INTR_EN. When it is defined, o_intr pulses once
// per consumed line. When it is undefined, o_intr is tied low.
module sobel_window_ctrl #(
  parameter int unsigned IMG_WIDTH = 512,
  parameter int unsigned CNT_W     = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr,
  output logic        o_overflow
);

  localparam logic [CNT_W-1:0] LastCol = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LastRc  = CNT_W'(IMG_WIDTH - 3);

  typedef enum logic {StIdle, StRdLine} state_e;

  state_e           state_q, state_d;
  logic [1:0]       wl_q, rl_q, rl_d;
  logic [CNT_W-1:0] wc_q, rc_q, rc_d;
  logic [2:0]       lines_full_q;
  logic             overflow_q;
  logic [71:0]      pix_out_q;
  logic             pix_valid_q;

  logic [7:0]       line_mem [4][IMG_WIDTH];

  logic             wr_accept;
  logic             wr_done;
  logic             rd_done;
  logic             issue;
  logic             line_ready;
  logic [1:0]       row_idx [3];
  logic [CNT_W-1:0] col_idx [3];
  logic [71:0]      window;

  // A full set of four buffers blocks writes, so rows under read are never overwritten.
  assign wr_accept  = i_pixel_data_valid && (lines_full_q != 3'd4);
  assign wr_done    = wr_accept && (wc_q == LastCol);
  assign line_ready = (lines_full_q >= 3'd3);

  // Line buffer storage; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      line_mem[wl_q][wc_q] <= i_pixel_data;
    end
  end

  // Write pointers: column wraps at line end and advances the write line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wc_q <= '0;
      wl_q <= '0;
    end else if (wr_accept) begin
      if (wr_done) begin
        wc_q <= '0;
        wl_q <= wl_q + 2'd1;
      end else begin
        wc_q <= wc_q + CNT_W'(1);
      end
    end
  end

  // Sticky flag for a pixel dropped because all buffers are full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow_q <= 1'b0;
    end else if (i_pixel_data_valid && (lines_full_q == 3'd4)) begin
      overflow_q <= 1'b1;
    end
  end

  // Count of complete, unconsumed lines; a simultaneous write and read completion cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lines_full_q <= '0;
    end else begin
      unique case ({wr_done, rd_done})
        2'b10:   lines_full_q <= lines_full_q + 3'd1;
        2'b01:   lines_full_q <= lines_full_q - 3'd1;
        default: lines_full_q <= lines_full_q;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      rc_q    <= '0;
      rl_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rl_q    <= rl_d;
    end
  end

  // Read FSM next state: one window per cycle in RD_LINE, then back to IDLE for one cycle.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    rl_d    = rl_q;
    issue   = 1'b0;
    rd_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line_ready) begin
          state_d = StRdLine;
          rc_d    = '0;
        end
      end
      StRdLine: begin
        issue = 1'b1;
        if (rc_q == LastRc) begin
          state_d = StIdle;
          rl_d    = rl_q + 2'd1;
          rd_done = 1'b1;
        end else begin
          rc_d = rc_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Row buffers and columns touched by the current window; row indices wrap mod 4.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      row_idx[i] = rl_q + 2'(i);
      col_idx[i] = rc_q + CNT_W'(i);
    end
  end

  // Pack the window: byte k = 3*row + column offset, with the top row in the low bytes.
  always_comb begin
    window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        window[8*(3*r+j) +: 8] = line_mem[row_idx[r]][col_idx[j]];
      end
    end
  end

  // Registered window output; data holds between lines, valid follows issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= issue;
      if (issue) begin
        pix_out_q <= window;
      end
    end
  end

`ifdef SOBEL_WINDOW_CTRL_INTR_EN
  logic intr_q;

  // Line-consumed pulse, one cycle after the last window of a line is issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= rd_done;
    end
  end

  assign o_intr = intr_q;
`else
  assign o_intr = 1'b0;
`endif

  assign o_pixel_data       = pix_out_q;
  assign o_pixel_data_valid = pix_valid_q;
  assign o_overflow         = overflow_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: directed checks of sobel_window_ctrl at IMG_WIDTH=8.
// Outputs are sampled on the falling edge. Inputs change 1 time unit after the rising edge.
module tb_sobel_window_ctrl;

  localparam int unsigned W = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pix;
  logic        pix_valid;
  logic [71:0] win;
  logic        win_valid;
  logic        intr;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  int          nc = 0;
  int          pix_nc [$];
  logic [71:0] win_d [$];
  int          win_nc [$];
  int          intr_nc [$];

  sobel_window_ctrl #(
    .IMG_WIDTH (W),
    .CNT_W     (3)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_valid),
    .o_pixel_data       (win),
    .o_pixel_data_valid (win_valid),
    .o_intr             (intr),
    .o_overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record input acceptances, windows and interrupts, indexed by falling-edge count.
  always @(negedge clk) begin
    nc = nc + 1;
    if (pix_valid) pix_nc.push_back(nc);
    if (win_valid) begin
      win_d.push_back(win);
      win_nc.push_back(nc);
    end
    if (intr) intr_nc.push_back(nc);
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int off, input int line, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++)
        w[8*(3*r+j) +: 8] = 8'(off + 8*(line + r) + col + j);
    return w;
  endfunction

  task automatic clear_mon();
    pix_nc.delete();
    win_d.delete();
    win_nc.delete();
    intr_nc.delete();
  endtask

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_data"}, win, 72'd0);
    check_eq({tag, "_valid"}, 72'(win_valid), 72'd0);
    check_eq({tag, "_intr"}, 72'(intr), 72'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix       = '0;
    #1;
    check_outs_zero("rst");
    check_eq("rst_ovf", 72'(overflow), 72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    clear_mon();
  endtask

  task automatic send_pix(input logic [7:0] d);
    @(posedge clk);
    #1;
    pix_valid = 1'b1;
    pix       = d;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  // Check n windows of a line against the model and against the expected issue timing.
  task automatic check_line(input string tag, input int first, input int off, input int line,
                            input int start_nc);
    for (int i = 0; i < W - 2; i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), win_d[first + i], exp_win(off, line, i));
      check_eq($sformatf("%s_t%0d", tag, i), 72'(win_nc[first + i]), 72'(start_nc + i));
    end
  endtask

  initial begin
    int seen;
    int guard;
    int last0;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix       = '0;

    // Continuous stream of 5 lines with pixel = 8*row + col.
    do_reset();
    for (int p = 0; p < 5 * W; p++) begin
      if (p == 23) check_eq("pre24_none", 72'(win_d.size()), 72'd0);
      send_pix(8'(p));
    end
    idle();
    repeat (20) @(posedge clk);
    #1;
    check_eq("a_count", 72'(win_d.size()), 72'd18);
    check_eq("a_first_lit", win_d[0],
             {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
    check_eq("a_last_lit", win_d[5],
             {8'd23, 8'd22, 8'd21, 8'd15, 8'd14, 8'd13, 8'd7, 8'd6, 8'd5});
    for (int l = 0; l < 3; l++)
      check_line($sformatf("a_l%0d", l), 6 * l, 0, l, pix_nc[8 * l + 23] + 3);
`ifdef SOBEL_WINDOW_CTRL_INTR_EN
    check_eq("a_intr_cnt", 72'(intr_nc.size()), 72'd3);
    for (int l = 0; l < 3; l++)
      check_eq($sformatf("a_intr_t%0d", l), 72'(intr_nc[l]), 72'(win_nc[6 * l + 5]));
`else
    check_eq("a_intr_cnt", 72'(intr_nc.size()), 72'd0);
`endif
    check_eq("a_ovf", 72'(overflow), 72'd0);

    // Hold the reader idle so that four lines fill, then present one pixel too many.
    do_reset();
    force dut.line_ready = 1'b0;
    for (int p = 0; p < 4 * W; p++) send_pix(8'(p));
    send_pix(8'hAA);
    check_eq("b_ovf_before", 72'(overflow), 72'd0);
    idle();
    check_eq("b_ovf_set", 72'(overflow), 72'd1);
    check_eq("b_wc", 72'(dut.wc_q), 72'd0);
    check_eq("b_wl", 72'(dut.wl_q), 72'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("b_none_stalled", 72'(win_d.size()), 72'd0);
    release dut.line_ready;
    repeat (25) @(posedge clk);
    #1;
    check_eq("b_count", 72'(win_d.size()), 72'd12);
    last0 = win_nc[5];
    check_line("b_l0", 0, 0, 0, win_nc[0]);
    check_line("b_l1", 6, 0, 1, last0 + 2);
    check_eq("b_ovf_sticky", 72'(overflow), 72'd1);

    // Reset while the third window of line 0 is on the output.
    do_reset();
    for (int p = 0; p < 3 * W; p++) send_pix(8'(p));
    idle();
    seen  = 0;
    guard = 0;
    while (seen < 3 && guard < 50) begin
      @(negedge clk);
      if (win_valid) seen++;
      guard++;
    end
    check_eq("c_reach_w3", 72'(seen), 72'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs_zero("c_mid");
    check_eq("c_mid_ovf", 72'(overflow), 72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    clear_mon();
    for (int p = 0; p < 3 * W; p++) send_pix(8'(100 + p));
    idle();
    repeat (15) @(posedge clk);
    #1;
    check_eq("c_count", 72'(win_d.size()), 72'd6);
    check_line("c_l0", 0, 100, 0, pix_nc[23] + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
